// File: rtl/key_event.sv
// key_event: turns a debounced key level into one-cycle short/long/double-click pulses
// and keeps a wrapping mode index. Double click is built only when KEY_DCLICK_EN is defined.
module key_event #(
  parameter logic        ACTIVE_LEVEL = 1'b0,
  parameter int unsigned LONG_CYCLES  = 50_000_000,
  parameter int unsigned DCLICK_GAP   = 12_500_000,
  parameter int unsigned MODE_W       = 3,
  parameter int unsigned MODE_MAX     = 7
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              key_in,
  output logic              short_pulse,
  output logic              long_pulse,
  output logic              double_pulse,
  output logic [MODE_W-1:0] key_mode,
  output logic [2:0]        state_dbg
);

  localparam int unsigned CNT_MAX = (LONG_CYCLES > DCLICK_GAP) ? LONG_CYCLES : DCLICK_GAP;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;
  localparam logic [CNT_W-1:0]  LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [MODE_W-1:0] MODE_TOP  = MODE_W'(MODE_MAX);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PRESS1 = 3'd1,
    S_WAIT2  = 3'd2,
    S_PRESS2 = 3'd3,
    S_HELD   = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               key_cur_q, key_prev_q;
  logic               short_q, short_d;
  logic               long_q, long_d;
  logic [MODE_W-1:0]  mode_q, mode_d;
  logic               press_ev, release_ev;

  // Both stages reset to the pressed level so a key held through reset is ignored.
  assign press_ev   = (key_cur_q == ACTIVE_LEVEL) && (key_prev_q != ACTIVE_LEVEL);
  assign release_ev = (key_cur_q != ACTIVE_LEVEL) && (key_prev_q == ACTIVE_LEVEL);

`ifdef KEY_DCLICK_EN
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(DCLICK_GAP - 1);
  logic double_q, double_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    short_d = 1'b0;
    long_d  = 1'b0;
`ifdef KEY_DCLICK_EN
    double_d = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (press_ev) state_d = S_PRESS1;
      end
      S_PRESS1: begin
        cnt_d = cnt_q + CNT_W'(1);
        // The long threshold takes priority over a release seen in the same cycle.
        if (cnt_q == LONG_LAST) begin
          long_d  = 1'b1;
          state_d = S_HELD;
        end else if (release_ev) begin
`ifdef KEY_DCLICK_EN
          state_d = S_WAIT2;
`else
          short_d = 1'b1;
          state_d = S_IDLE;
`endif
        end
      end
`ifdef KEY_DCLICK_EN
      S_WAIT2: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (press_ev) begin
          state_d = S_PRESS2;
        end else if (cnt_q == GAP_LAST) begin
          short_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_PRESS2: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LONG_LAST) begin
          long_d  = 1'b1;
          state_d = S_HELD;
        end else if (release_ev) begin
          double_d = 1'b1;
          state_d  = S_IDLE;
        end
      end
`endif
      S_HELD: begin
        if (release_ev) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  always_comb begin
    mode_d = mode_q;
    if (long_d) begin
      mode_d = '0;
    end else if (short_d) begin
      mode_d = (mode_q == MODE_TOP) ? '0 : mode_q + MODE_W'(1);
    end
`ifdef KEY_DCLICK_EN
    else if (double_d) begin
      mode_d = (mode_q == '0) ? MODE_TOP : mode_q - MODE_W'(1);
    end
`endif
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      key_cur_q  <= ACTIVE_LEVEL;
      key_prev_q <= ACTIVE_LEVEL;
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      short_q    <= 1'b0;
      long_q     <= 1'b0;
      mode_q     <= '0;
`ifdef KEY_DCLICK_EN
      double_q   <= 1'b0;
`endif
    end else begin
      key_cur_q  <= key_in;
      key_prev_q <= key_cur_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      short_q    <= short_d;
      long_q     <= long_d;
      mode_q     <= mode_d;
`ifdef KEY_DCLICK_EN
      double_q   <= double_d;
`endif
    end
  end

  assign short_pulse = short_q;
  assign long_pulse  = long_q;
  assign key_mode    = mode_q;
  assign state_dbg   = state_q;
`ifdef KEY_DCLICK_EN
  assign double_pulse = double_q;
`else
  assign double_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_key_event.sv
// Directed bench for key_event: pulse timing measured in clock edges from the key_in change,
// mode index tracked by a small reference model; works with or without KEY_DCLICK_EN.
`timescale 1ns/1ps
module tb_key_event;
  localparam int LONG = 100;
  localparam int GAP  = 40;
  localparam int MW   = 2;
  localparam int MMAX = 3;
`ifdef KEY_DCLICK_EN
  localparam int LAT_SHORT = GAP + 2;
`else
  localparam int LAT_SHORT = 2;
`endif
  localparam int LAT_LONG = LONG + 2;
  localparam int LAT_DBL  = 2;

  logic          clk = 1'b0;
  logic          nrst = 1'b0;
  logic          key_in = 1'b0;
  logic          short_pulse, long_pulse, double_pulse;
  logic [MW-1:0] key_mode;
  logic [2:0]    state_dbg;

  int            cyc = 0;
  int            n_checks = 0;
  int            n_err = 0;
  int            multi = 0;
  logic [31:0]   exp_q[$];
  logic [31:0]   obs_q[$];
  logic [MW-1:0] exp_mode = '0;
  int            t_rel, t_rel2, t_prs;

  key_event #(
    .ACTIVE_LEVEL(1'b0),
    .LONG_CYCLES (LONG),
    .DCLICK_GAP  (GAP),
    .MODE_W      (MW),
    .MODE_MAX    (MMAX)
  ) dut (
    .clk         (clk),
    .nrst        (nrst),
    .key_in      (key_in),
    .short_pulse (short_pulse),
    .long_pulse  (long_pulse),
    .double_pulse(double_pulse),
    .key_mode    (key_mode),
    .state_dbg   (state_dbg)
  );

  // Clock and edge counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  // Event monitor: {kind, edge number}; kind 1 short, 2 long, 3 double
  always @(posedge clk) begin
    #1;
    if (int'(short_pulse) + int'(long_pulse) + int'(double_pulse) > 1) multi++;
    if (short_pulse)  obs_q.push_back({2'd1, cyc[29:0]});
    if (long_pulse)   obs_q.push_back({2'd2, cyc[29:0]});
    if (double_pulse) obs_q.push_back({2'd3, cyc[29:0]});
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_key(input logic v, output int t);
    key_in = v;
    t = cyc;
  endtask

  task automatic tap(input int hold, output int t_r);
    int t_p;
    set_key(1'b0, t_p);
    idle(hold);
    set_key(1'b1, t_r);
  endtask

  task automatic push_exp(input logic [1:0] kind, input int at);
    exp_q.push_back({kind, at[29:0]});
    case (kind)
      2'd1: exp_mode = (exp_mode == MW'(MMAX)) ? '0 : exp_mode + MW'(1);
      2'd2: exp_mode = '0;
      2'd3: exp_mode = (exp_mode == '0) ? MW'(MMAX) : exp_mode - MW'(1);
      default: ;
    endcase
  endtask

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_events(input string tag);
    logic [31:0] e, o;
    n_checks++;
    assert (obs_q.size() === exp_q.size()) else begin
      n_err++;
      $error("FAIL %s event count: observed %0d expected %0d", tag, obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_checks++;
      assert (o === e) else begin
        n_err++;
        $error("FAIL %s event: observed kind %0d edge %0d expected kind %0d edge %0d",
               tag, o[31:30], o[29:0], e[31:30], e[29:0]);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  initial begin
    // Reset with the key held pressed
    nrst = 1'b0;
    key_in = 1'b0;
    idle(3);
    check_val("rst_short",  32'(short_pulse),  32'd0);
    check_val("rst_long",   32'(long_pulse),   32'd0);
    check_val("rst_double", 32'(double_pulse), 32'd0);
    check_val("rst_mode",   32'(key_mode),     32'd0);
    check_val("rst_state",  32'(state_dbg),    32'd0);
    nrst = 1'b1;
    idle(10);
    set_key(1'b1, t_rel);
    idle(60);
    check_events("held_through_reset");
    check_val("held_mode", 32'(key_mode), 32'd0);

    // Four short presses walk the mode 1,2,3,0
    for (int i = 0; i < 4; i++) begin
      tap(30, t_rel);
      push_exp(2'd1, t_rel + LAT_SHORT);
      idle(60);
      check_events($sformatf("short%0d", i));
      check_val($sformatf("short%0d_mode", i), 32'(key_mode), 32'(exp_mode));
    end

    // Two clicks 10 cycles apart
    tap(30, t_rel);
    idle(10);
    tap(30, t_rel2);
`ifdef KEY_DCLICK_EN
    push_exp(2'd3, t_rel2 + LAT_DBL);
`else
    push_exp(2'd1, t_rel + 2);
    push_exp(2'd1, t_rel2 + 2);
`endif
    idle(60);
    check_events("two_clicks");
    check_val("two_clicks_mode", 32'(key_mode), 32'(exp_mode));

    // Long hold from a nonzero mode
    set_key(1'b0, t_prs);
    push_exp(2'd2, t_prs + LAT_LONG);
    idle(150);
    check_val("long_held_state", 32'(state_dbg), 32'd4);
    set_key(1'b1, t_rel);
    idle(60);
    check_events("long");
    check_val("long_mode", 32'(key_mode), 32'd0);
    check_val("long_exit_state", 32'(state_dbg), 32'd0);

    // Reset asserted 20 cycles into the release gap
    tap(30, t_rel);
    push_exp(2'd1, t_rel + LAT_SHORT);
    idle(60);
    check_events("pre_reset_short");
    tap(30, t_rel);
`ifndef KEY_DCLICK_EN
    push_exp(2'd1, t_rel + 2);
`endif
    idle(20);
    nrst = 1'b0;
    #1;
    check_val("async_rst_mode",  32'(key_mode),  32'd0);
    check_val("async_rst_state", 32'(state_dbg), 32'd0);
    check_val("async_rst_short", 32'(short_pulse), 32'd0);
    idle(5);
    nrst = 1'b1;
    exp_mode = '0;
    idle(80);
    check_events("reset_in_gap");
    check_val("reset_in_gap_mode", 32'(key_mode), 32'd0);

    // Release lands in the same cycle as the long threshold: long wins, release is consumed
    tap(30, t_rel);
    push_exp(2'd1, t_rel + LAT_SHORT);
    idle(60);
    check_events("pre_b1_short");
    set_key(1'b0, t_prs);
    idle(LONG);
    set_key(1'b1, t_rel);
    push_exp(2'd2, t_prs + LAT_LONG);
    idle(60);
    check_events("long_vs_release");
    check_val("long_vs_release_mode", 32'(key_mode), 32'd0);
    check_val("long_vs_release_state", 32'(state_dbg), 32'd4);
    tap(30, t_rel);
    idle(20);
    check_events("held_exit");
    check_val("held_exit_state", 32'(state_dbg), 32'd0);

    // Second press lands in the same cycle as gap expiry
    tap(30, t_rel);
    idle(GAP);
    set_key(1'b0, t_prs);
    idle(30);
    set_key(1'b1, t_rel2);
`ifdef KEY_DCLICK_EN
    push_exp(2'd3, t_rel2 + LAT_DBL);
`else
    push_exp(2'd1, t_rel + 2);
    push_exp(2'd1, t_rel2 + 2);
`endif
    idle(60);
    check_events("press_vs_gap");
    check_val("press_vs_gap_mode", 32'(key_mode), 32'(exp_mode));

    check_val("one_pulse_per_cycle", 32'(multi), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
